mem_port_arbiter: RTL and testbench

- Arbitrates a single-port unified memory between the instruction-fetch stage (IF, read-only) and the data-memory stage (D, read/write).
- Sequences each access over a fixed memory latency and drives active-low CSN/WEN strobes to the memory.
- Generates PIPE_ENABLE, which drives the ENABLE inputs of the pipeline registers so the pipeline freezes while an access is outstanding.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_port_arbiter.
// The arbiter uses the slave modport; pipeline/memory models use master.
interface mem_port_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          m_csn;
    logic          m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          pipe_enable;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               m_csn, m_wen, m_addr, m_wdata, pipe_enable
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               m_csn, m_wen, m_addr, m_wdata, pipe_enable
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and data stage (D).
// Optional macro MEM_ARB_STARVE_GUARD_EN adds a fetch starvation guard.
module mem_port_arbiter #(
    parameter int AW           = 12,
    parameter int DW           = 32,
    parameter int LATENCY      = 1,   // 1..15
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    mem_port_arbiter_if.slave     bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);

    logic [1:0]    state_q,     state_d;
    logic [3:0]    cnt_q,       cnt_d;
    logic          own_data_q,  own_data_d;
    logic          we_q,        we_d;
    logic [AW-1:0] m_addr_q,    m_addr_d;
    logic [DW-1:0] m_wdata_q,   m_wdata_d;
    logic          m_csn_q,     m_csn_d;
    logic          m_wen_q,     m_wen_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          d_rvalid_q,  d_rvalid_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] d_rdata_q,   d_rdata_d;

    logic grant_if_s;
    logic grant_d_s;
    logic force_if_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    assign force_if_s = (starve_q == STARVE_MAX);

    // Starvation counter: counts D wins over a waiting fetch, cleared by an IF grant
    always_comb begin
        starve_d = starve_q;
        if (grant_if_s) begin
            starve_d = '0;
        end else if (grant_d_s && bus.if_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if_s = 1'b0;
`endif

    // Arbitration: D (older instruction) wins unless the starvation guard forces IF
    always_comb begin
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.d_req && !(force_if_s && bus.if_req)) begin
                grant_d_s = 1'b1;
            end else if (bus.if_req) begin
                grant_if_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
            end
        end else begin
            grant_if_s = 1'b0;
        end
    end

    // Next-state and registered-output logic of the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        own_data_d  = own_data_q;
        we_d        = we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_csn_d     = m_csn_q;
        m_wen_d     = m_wen_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_s) begin
                    state_d    = ST_ACCESS;
                    cnt_d      = CNT_LOAD;
                    own_data_d = 1'b1;
                    we_d       = bus.d_we;
                    m_addr_d   = bus.d_addr;
                    m_wdata_d  = bus.d_wdata;
                    m_csn_d    = 1'b0;
                    m_wen_d    = ~bus.d_we;
                end else if (grant_if_s) begin
                    state_d    = ST_ACCESS;
                    cnt_d      = CNT_LOAD;
                    own_data_d = 1'b0;
                    we_d       = 1'b0;
                    m_addr_d   = bus.if_addr;
                    m_wdata_d  = '0;
                    m_csn_d    = 1'b0;
                    m_wen_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    m_csn_d = 1'b1;
                    m_wen_d = 1'b1;
                    if (own_data_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = we_q ? '0 : bus.m_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                m_csn_d = 1'b1;
                m_wen_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            own_data_q  <= 1'b0;
            we_q        <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_csn_q     <= 1'b1;
            m_wen_q     <= 1'b1;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            own_data_q  <= own_data_d;
            we_q        <= we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_csn_q     <= m_csn_d;
            m_wen_q     <= m_wen_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.if_gnt    = grant_if_s;
    assign bus.d_gnt     = grant_d_s;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.m_csn     = m_csn_q;
    assign bus.m_wen     = m_wen_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;

    // Pipeline may advance when nothing is pending or the pending access completes now
    assign bus.pipe_enable = ~((bus.if_req & ~if_rvalid_q) | (bus.d_req & ~d_rvalid_q));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: cycle table on a LATENCY=1 instance, hand sequences on LATENCY=3.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(12), .DW(32)) bus1 ();
    mem_port_arbiter_if #(.AW(12), .DW(32)) bus3 ();

    mem_port_arbiter #(.AW(12), .DW(32), .LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clk_i (clk),
        .rst_i (rst1),
        .bus   (bus1.slave)
    );

    mem_port_arbiter #(.AW(12), .DW(32), .LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clk_i (clk),
        .rst_i (rst3),
        .bus   (bus3.slave)
    );

    typedef struct {
        logic        if_req;
        logic [11:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [11:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] m_rdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_if_rv;
        logic        e_d_rv;
        logic [31:0] e_if_rdata;
        logic [31:0] e_d_rdata;
        logic        e_csn;
        logic        e_wen;
        logic [11:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_pipe;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic d3_access(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                             input logic [31:0] mr, input logic [31:0] exp_rd);
        bus3.d_req   = 1'b1;
        bus3.d_we    = we;
        bus3.d_addr  = addr;
        bus3.d_wdata = wd;
        bus3.m_rdata = mr;
        @(negedge clk);
        chk("l3.d_gnt", 32'(bus3.d_gnt), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            bus3.d_addr = 12'hFFF;
            @(negedge clk);
            chk($sformatf("l3.csn_acc%0d", k), 32'(bus3.m_csn), 32'd0);
            chk($sformatf("l3.wen_acc%0d", k), 32'(bus3.m_wen), 32'(!we));
            chk($sformatf("l3.addr_acc%0d", k), 32'(bus3.m_addr), 32'(addr));
            chk($sformatf("l3.rvalid_acc%0d", k), 32'(bus3.d_rvalid), 32'd0);
        end
        cyc();
        @(negedge clk);
        chk("l3.d_rvalid_done", 32'(bus3.d_rvalid), 32'd1);
        chk("l3.d_rdata_done", bus3.d_rdata, exp_rd);
        chk("l3.csn_done", 32'(bus3.m_csn), 32'd1);
        chk("l3.wen_done", 32'(bus3.m_wen), 32'd1);
        cyc();
        bus3.d_req = 1'b0;
        @(negedge clk);
        chk("l3.d_rvalid_pulse", 32'(bus3.d_rvalid), 32'd0);
        chk("l3.d_rdata_hold", bus3.d_rdata, exp_rd);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          got[$];
        logic [31:0] exp_if;

        //            if  ifaddr   d  we daddr    dwdata         mrdata        |ifg dg ifr dr if_rdata      d_rdata       csn wen maddr   mwdata        pipe
        vecs[0]  = '{1'b0,12'h000,1'b0,1'b0,12'h000,32'h00000000,32'h00000000, 1'b0,1'b0,1'b0,1'b0,32'h00000000,32'h00000000,1'b1,1'b1,12'h000,32'h00000000,1'b1};
        vecs[1]  = '{1'b1,12'h010,1'b0,1'b0,12'h000,32'h00000000,32'hDEADBEEF, 1'b1,1'b0,1'b0,1'b0,32'h00000000,32'h00000000,1'b1,1'b1,12'h000,32'h00000000,1'b0};
        vecs[2]  = '{1'b1,12'h010,1'b0,1'b0,12'h000,32'h00000000,32'hDEADBEEF, 1'b0,1'b0,1'b0,1'b0,32'h00000000,32'h00000000,1'b0,1'b1,12'h010,32'h00000000,1'b0};
        vecs[3]  = '{1'b1,12'h010,1'b0,1'b0,12'h000,32'h00000000,32'hDEADBEEF, 1'b0,1'b0,1'b1,1'b0,32'hDEADBEEF,32'h00000000,1'b1,1'b1,12'h010,32'h00000000,1'b1};
        vecs[4]  = '{1'b1,12'h044,1'b1,1'b1,12'h020,32'h12345678,32'hCAFEF00D, 1'b0,1'b1,1'b0,1'b0,32'hDEADBEEF,32'h00000000,1'b1,1'b1,12'h010,32'h00000000,1'b0};
        vecs[5]  = '{1'b1,12'h044,1'b1,1'b1,12'h020,32'h12345678,32'hCAFEF00D, 1'b0,1'b0,1'b0,1'b0,32'hDEADBEEF,32'h00000000,1'b0,1'b0,12'h020,32'h12345678,1'b0};
        vecs[6]  = '{1'b1,12'h044,1'b1,1'b1,12'h020,32'h12345678,32'hCAFEF00D, 1'b0,1'b0,1'b0,1'b1,32'hDEADBEEF,32'h00000000,1'b1,1'b1,12'h020,32'h12345678,1'b0};
        vecs[7]  = '{1'b1,12'h044,1'b0,1'b0,12'h000,32'h00000000,32'hCAFEF00D, 1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF,32'h00000000,1'b1,1'b1,12'h020,32'h12345678,1'b0};
        vecs[8]  = '{1'b1,12'h3FF,1'b0,1'b0,12'h000,32'h00000000,32'hCAFEF00D, 1'b0,1'b0,1'b0,1'b0,32'hDEADBEEF,32'h00000000,1'b0,1'b1,12'h044,32'h00000000,1'b0};
        vecs[9]  = '{1'b1,12'h3FF,1'b0,1'b0,12'h000,32'h00000000,32'hCAFEF00D, 1'b0,1'b0,1'b1,1'b0,32'hCAFEF00D,32'h00000000,1'b1,1'b1,12'h044,32'h00000000,1'b1};
        vecs[10] = '{1'b0,12'h000,1'b1,1'b0,12'h0AB,32'h00000000,32'h0BADC0DE, 1'b0,1'b1,1'b0,1'b0,32'hCAFEF00D,32'h00000000,1'b1,1'b1,12'h044,32'h00000000,1'b0};
        vecs[11] = '{1'b0,12'h000,1'b0,1'b0,12'h0AB,32'h00000000,32'h0BADC0DE, 1'b0,1'b0,1'b0,1'b0,32'hCAFEF00D,32'h00000000,1'b0,1'b1,12'h0AB,32'h00000000,1'b1};
        vecs[12] = '{1'b0,12'h000,1'b0,1'b0,12'h000,32'h00000000,32'h0BADC0DE, 1'b0,1'b0,1'b0,1'b1,32'hCAFEF00D,32'h0BADC0DE,1'b1,1'b1,12'h0AB,32'h00000000,1'b1};
        vecs[13] = '{1'b0,12'h000,1'b0,1'b0,12'h000,32'h00000000,32'h00000000, 1'b0,1'b0,1'b0,1'b0,32'hCAFEF00D,32'h0BADC0DE,1'b1,1'b1,12'h0AB,32'h00000000,1'b1};

        {bus1.if_req, bus1.d_req, bus1.d_we} = 3'b000;
        bus1.if_addr = 12'h000; bus1.d_addr = 12'h000;
        bus1.d_wdata = 32'h0;   bus1.m_rdata = 32'h0;
        {bus3.if_req, bus3.d_req, bus3.d_we} = 3'b000;
        bus3.if_addr = 12'h000; bus3.d_addr = 12'h000;
        bus3.d_wdata = 32'h0;   bus3.m_rdata = 32'h0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        cyc();
        cyc();
        rst1 = 1'b0;
        rst3 = 1'b0;

        // Cycle-by-cycle table on the LATENCY=1 instance
        for (int i = 0; i < 14; i++) begin
            bus1.if_req  = vecs[i].if_req;
            bus1.if_addr = vecs[i].if_addr;
            bus1.d_req   = vecs[i].d_req;
            bus1.d_we    = vecs[i].d_we;
            bus1.d_addr  = vecs[i].d_addr;
            bus1.d_wdata = vecs[i].d_wdata;
            bus1.m_rdata = vecs[i].m_rdata;
            @(negedge clk);
            chk($sformatf("v%0d.if_gnt", i),    32'(bus1.if_gnt),      32'(vecs[i].e_if_gnt));
            chk($sformatf("v%0d.d_gnt", i),     32'(bus1.d_gnt),       32'(vecs[i].e_d_gnt));
            chk($sformatf("v%0d.if_rvalid", i), 32'(bus1.if_rvalid),   32'(vecs[i].e_if_rv));
            chk($sformatf("v%0d.d_rvalid", i),  32'(bus1.d_rvalid),    32'(vecs[i].e_d_rv));
            chk($sformatf("v%0d.if_rdata", i),  bus1.if_rdata,         vecs[i].e_if_rdata);
            chk($sformatf("v%0d.d_rdata", i),   bus1.d_rdata,          vecs[i].e_d_rdata);
            chk($sformatf("v%0d.m_csn", i),     32'(bus1.m_csn),       32'(vecs[i].e_csn));
            chk($sformatf("v%0d.m_wen", i),     32'(bus1.m_wen),       32'(vecs[i].e_wen));
            chk($sformatf("v%0d.m_addr", i),    32'(bus1.m_addr),      32'(vecs[i].e_addr));
            chk($sformatf("v%0d.m_wdata", i),   bus1.m_wdata,          vecs[i].e_wdata);
            chk($sformatf("v%0d.pipe_en", i),   32'(bus1.pipe_enable), 32'(vecs[i].e_pipe));
            cyc();
        end

        // LATENCY=3: read, write (D_RDATA returns to 0), read again
        @(negedge clk);
        chk("l3.reset_csn", 32'(bus3.m_csn), 32'd1);
        chk("l3.reset_wen", 32'(bus3.m_wen), 32'd1);
        cyc();
        d3_access(1'b0, 12'h0F0, 32'h00000000, 32'h11112222, 32'h11112222);
        d3_access(1'b1, 12'h0F0, 32'hA5A5A5A5, 32'h99999999, 32'h00000000);
        d3_access(1'b0, 12'h0F8, 32'h00000000, 32'h33334444, 32'h33334444);

        // Reset during the second ACCESS cycle of a write
        bus3.d_req   = 1'b1;
        bus3.d_we    = 1'b1;
        bus3.d_addr  = 12'h0F4;
        bus3.d_wdata = 32'h5A5A5A5A;
        @(negedge clk);
        chk("rst.d_gnt", 32'(bus3.d_gnt), 32'd1);
        cyc();
        cyc();
        chk("rst.pre_csn", 32'(bus3.m_csn), 32'd0);
        chk("rst.pre_wen", 32'(bus3.m_wen), 32'd0);
        rst3 = 1'b1;
        #1;
        chk("rst.csn", 32'(bus3.m_csn), 32'd1);
        chk("rst.wen", 32'(bus3.m_wen), 32'd1);
        chk("rst.m_addr", 32'(bus3.m_addr), 32'd0);
        chk("rst.m_wdata", bus3.m_wdata, 32'd0);
        chk("rst.d_rdata", bus3.d_rdata, 32'd0);
        bus3.d_req = 1'b0;
        cyc();
        rst3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rst.no_rvalid%0d", k), 32'({bus3.d_rvalid, bus3.if_rvalid, bus3.m_csn}), 32'b001);
            cyc();
        end
        bus3.if_req  = 1'b1;
        bus3.if_addr = 12'h123;
        bus3.m_rdata = 32'h76543210;
        @(negedge clk);
        chk("rst.idle_regrant", 32'(bus3.if_gnt), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc();
        end
        @(negedge clk);
        chk("rst.if_rvalid_after", 32'(bus3.if_rvalid), 32'd1);
        chk("rst.if_rdata_after", bus3.if_rdata, 32'h76543210);
        cyc();
        bus3.if_req = 1'b0;

        // Both requests held high on the LATENCY=1 instance: record grant order
        rst1 = 1'b1;
        cyc();
        rst1 = 1'b0;
        bus1.if_req  = 1'b1;
        bus1.if_addr = 12'h100;
        bus1.d_req   = 1'b1;
        bus1.d_we    = 1'b0;
        bus1.d_addr  = 12'h200;
        for (int c = 0; c < 400 && got.size() < 20; c++) begin
            @(negedge clk);
            if (bus1.if_gnt) begin
                got.push_back(1);
            end else if (bus1.d_gnt) begin
                got.push_back(0);
            end
            cyc();
        end
        chk("starve.grant_count", 32'(got.size()), 32'd20);
        for (int i = 0; i < got.size(); i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = ((i % 5) == 4) ? 32'd1 : 32'd0;
`else
            exp_if = 32'd0;
`endif
            chk($sformatf("starve.grant%0d_is_if", i), 32'(got[i]), exp_if);
        end
        bus1.if_req = 1'b0;
        bus1.d_req  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
